sum_job_scheduler: RTL and testbench

- Shares one triangular-sum engine (computes 0+1+…+n for n in 0..15) between two independent requesters.
- Round-robin arbitration picks a requester, issues a start pulse with its operand, and waits for the engine's done handshake.
- Latches the 8-bit result into that requester's result register and acknowledges it.
- Sits between the switch/FSM front-ends and the shared sum engine; result registers feed the 7-segment display path.

---
 rtl/sum_job_scheduler_pkg.sv | 15 +
 rtl/sum_job_scheduler_rr_arb2.sv | 29 ++
 rtl/sum_job_scheduler.sv | 138 +++++++++++++
 tb/tb_sum_job_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_job_scheduler_pkg.sv
// Shared types and constants for the triangular-sum job scheduler.
package sum_job_scheduler_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 8;
    localparam logic [RES_W-1:0] ERR_CODE_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sum_job_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the pointer favours the requester not served last.
module sum_job_scheduler_rr_arb2 (
    input  logic       clk,
    input  logic       rst_a_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       served,
    output logic [1:0] grant
);

    logic pointer;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            pointer <= 1'b0;
        end else if (advance) begin
            pointer <= ~served;
        end
    end

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = pointer ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/sum_job_scheduler.sv
// Shares one triangular-sum engine between two requesters, one job at a time.
//   state    | meaning
//   ST_IDLE  | waiting for a request; grant and capture operand on exit
//   ST_ISSUE | one-cycle start pulse to the engine, timeout counter cleared
//   ST_WAIT  | waiting for eng_done or timeout; result written on exit
//   ST_DONE  | ack the served requester, advance the round-robin pointer
module sum_job_scheduler
    import sum_job_scheduler_pkg::*;
#(
    parameter int               TIMEOUT  = 64,
    parameter logic [RES_W-1:0] ERR_CODE = ERR_CODE_DEF
) (
    input  logic              clk,
    input  logic              rst_a_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [OPND_W-1:0] n0,
    input  logic [OPND_W-1:0] n1,
    output logic              ack0,
    output logic              ack1,
    output logic [RES_W-1:0]  res0,
    output logic [RES_W-1:0]  res1,
    output logic              eng_start,
    output logic [OPND_W-1:0] eng_n,
    input  logic              eng_done,
    input  logic [RES_W-1:0]  eng_sum,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic             id;
    logic [1:0]       grant;
    logic             take;
    logic             advance;
    logic             hit;
    logic             expired;
    logic [CNT_W-1:0] cnt;
    logic [RES_W-1:0] wr_val;

    sum_job_scheduler_rr_arb2 u_arb (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .req     ({req1, req0}),
        .advance (advance),
        .served  (id),
        .grant   (grant)
    );

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        eng_start = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        take      = 1'b0;
        advance   = 1'b0;
        hit       = 1'b0;
        expired   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (|grant) begin
                    take      = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_start = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the last allowed cycle beats the timeout.
                if (eng_done) begin
                    hit       = 1'b1;
                    state_nxt = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    expired   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                ack0      = ~id;
                ack1      = id;
                advance   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wr_val = hit ? eng_sum : ERR_CODE;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            id    <= 1'b0;
            eng_n <= '0;
            err   <= 1'b0;
            res0  <= '0;
            res1  <= '0;
            cnt   <= '0;
        end else begin
            if (take) begin
                id    <= grant[1];
                eng_n <= grant[1] ? n1 : n0;
                err   <= 1'b0;
            end
            if (state == ST_ISSUE) begin
                cnt <= '0;
            end else if (state == ST_WAIT && cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (hit || expired) begin
                if (id) begin
                    res1 <= wr_val;
                end else begin
                    res0 <= wr_val;
                end
            end
            if (expired) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sum_job_scheduler.sv
// Directed and randomized jobs against a job-level model of arbitration, results and timing.
module tb_sum_job_scheduler;

    localparam int TO = 64;

    logic       clk;
    logic       rst_a_n;
    logic       req0, req1;
    logic [3:0] n0, n1;
    logic       ack0, ack1;
    logic [7:0] res0, res1;
    logic       eng_start;
    logic [3:0] eng_n;
    logic       eng_done;
    logic [7:0] eng_sum;
    logic       busy;
    logic       err;

    int         vectors;
    int         miscompares;
    logic [7:0] res_m [2];
    logic       err_m;
    int         ptr_m;

    sum_job_scheduler #(.TIMEOUT(TO), .ERR_CODE(8'hFF)) dut (
        .clk       (clk),
        .rst_a_n   (rst_a_n),
        .req0      (req0),
        .req1      (req1),
        .n0        (n0),
        .n1        (n1),
        .ack0      (ack0),
        .ack1      (ack1),
        .res0      (res0),
        .res1      (res1),
        .eng_start (eng_start),
        .eng_n     (eng_n),
        .eng_done  (eng_done),
        .eng_sum   (eng_sum),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        res_m[0] = 8'h00;
        res_m[1] = 8'h00;
        err_m    = 1'b0;
        ptr_m    = 0;
    endtask

    task automatic reset_dut();
        rst_a_n  = 1'b0;
        req0     = 1'b0;
        req1     = 1'b0;
        eng_done = 1'b0;
        model_reset();
        #2;
        rst_a_n = 1'b1;
        tick();
    endtask

    // Entered in an IDLE cycle with requests already set; dly=0 means the engine never answers.
    task automatic do_job(input int dly, input logic [1:0] drop, input logic [1:0] nxt);
        int         id_e;
        int         ni;
        int         k;
        int         total;
        logic [3:0] n_e;
        logic [7:0] s_e;
        if (req0 && req1) id_e = ptr_m;
        else id_e = req1 ? 1 : 0;
        n_e = (id_e == 1) ? n1 : n0;
        ni  = int'(n_e);
        s_e = 8'(ni * (ni + 1) / 2);
        k = 0;
        while (!eng_start && k < 8) begin
            tick();
            k++;
        end
        chk("grant_latency", k, 1);
        if (!eng_start) return;
        chk("eng_n_at_issue", eng_n, n_e);
        chk("busy_issue", busy, 1);
        chk("err_cleared_at_grant", err, 0);
        if (drop[0]) req0 = 1'b0;
        if (drop[1]) req1 = 1'b0;
        n0       = 4'($urandom);
        n1       = 4'($urandom);
        eng_done = 1'($urandom_range(0, 1));
        eng_sum  = 8'($urandom);
        total = (dly == 0) ? TO : dly;
        for (int c = 1; c <= total; c++) begin
            tick();
            if (c == 1) chk("start_one_cycle", eng_start, 0);
            chk("no_early_ack", {ack1, ack0}, 0);
            eng_done = (c == dly);
            eng_sum  = (c == dly) ? s_e : 8'($urandom);
        end
        tick();
        eng_done = 1'b0;
        if (dly == 0) begin
            res_m[id_e] = 8'hFF;
            err_m       = 1'b1;
        end else begin
            res_m[id_e] = s_e;
            err_m       = 1'b0;
        end
        chk("ack0_done", ack0, id_e == 0);
        chk("ack1_done", ack1, id_e == 1);
        chk("res0_done", res0, res_m[0]);
        chk("res1_done", res1, res_m[1]);
        chk("err_done", err, err_m);
        chk("eng_n_stable", eng_n, n_e);
        chk("busy_done", busy, 1);
        ptr_m = 1 - id_e;
        req0 = nxt[0];
        req1 = nxt[1];
        tick();
        chk("ack_one_cycle", {ack1, ack0}, 0);
        chk("idle_not_busy", busy, 0);
        chk("res0_held", res0, res_m[0]);
        chk("res1_held", res1, res_m[1]);
        chk("err_held", err, err_m);
    endtask

    initial begin
        int         k;
        int         p;
        int         d;
        logic [1:0] dr;
        vectors     = 0;
        miscompares = 0;
        model_reset();
        rst_a_n  = 1'b0;
        req0     = 1'b0;
        req1     = 1'b0;
        n0       = 4'd0;
        n1       = 4'd0;
        eng_done = 1'b0;
        eng_sum  = 8'd0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_acks", {ack1, ack0}, 0);
        chk("rst_res0", res0, 0);
        chk("rst_res1", res1, 0);
        chk("rst_err", err, 0);
        chk("rst_eng_n", eng_n, 0);
        #2;
        rst_a_n = 1'b1;
        tick();

        // Single requester, engine answers 3 cycles after start.
        req0 = 1'b1; n0 = 4'd4;
        do_job(3, 2'b00, 2'b00);

        // Both requesting from reset: alternate 0,1,0,1.
        reset_dut();
        req0 = 1'b1; req1 = 1'b1; n0 = 4'd3; n1 = 4'd5;
        do_job(2, 2'b00, 2'b11);
        n0 = 4'd3; n1 = 4'd5;
        do_job(5, 2'b00, 2'b11);
        n0 = 4'd9; n1 = 4'd12;
        do_job(1, 2'b00, 2'b11);
        n0 = 4'd2; n1 = 4'd7;
        do_job(4, 2'b00, 2'b00);

        // Timeout, then err clears at the following grant.
        req0 = 1'b1; n0 = 4'd8;
        do_job(0, 2'b01, 2'b00);
        req1 = 1'b1; n1 = 4'd6;
        do_job(TO, 2'b10, 2'b00);
        req0 = 1'b1; n0 = 4'd6;
        do_job(TO - 1, 2'b01, 2'b00);

        // Request dropped one cycle after grant still completes.
        req1 = 1'b1; n1 = 4'd15;
        do_job(4, 2'b10, 2'b00);

        for (int i = 0; i < 16; i++) begin
            p  = int'($urandom_range(1, 3));
            req0 = p[0];
            req1 = p[1];
            n0 = 4'($urandom);
            n1 = 4'($urandom);
            d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
            dr = 2'($urandom);
            do_job(d, dr, 2'b00);
        end

        // Serve requester 0 so the pointer favours 1, then reset mid-job.
        req0 = 1'b1; n0 = 4'd10;
        do_job(2, 2'b01, 2'b00);
        req0 = 1'b1; n0 = 4'd7;
        k = 0;
        while (!eng_start && k < 8) begin
            tick();
            k++;
        end
        chk("rst_job_start", eng_start, 1);
        tick();
        tick();
        tick();
        #2;
        rst_a_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_busy", busy, 0);
        chk("midrst_start", eng_start, 0);
        chk("midrst_acks", {ack1, ack0}, 0);
        chk("midrst_res0", res0, 0);
        chk("midrst_res1", res1, 0);
        chk("midrst_err", err, 0);
        chk("midrst_eng_n", eng_n, 0);
        req0 = 1'b0;
        tick();
        chk("midrst_no_ack", {ack1, ack0}, 0);
        #2;
        rst_a_n = 1'b1;
        tick();
        req0 = 1'b1; req1 = 1'b1; n0 = 4'd11; n1 = 4'd13;
        do_job(3, 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
